// File: rtl/ps2_rx_frame_decoder.sv
// ps2_rx_frame_decoder: PS/2 keyboard-to-host frame receiver presenting each accepted scan-code byte in parallel.
// Ports:
//   clk      - PS/2 device clock; all state advances on its falling edge (mid-bit sampling)
//   rst      - asynchronous active-high reset
//   data_in  - PS/2 data line, idle high
//   data_out - last accepted scan code, held until the next accepted frame
//   bsy      - 1 while idle after reset or while a frame is in progress; 0 when data_out is fresh
// Build option: define PS2_PARITY_CHECK_EN to reject frames failing odd parity;
// otherwise the parity bit is sampled but ignored.
module ps2_rx_frame_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       bsy
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic       par_q, par_d;
  logic [7:0] dout_q, dout_d;
  logic       bsy_q, bsy_d;
  logic       accept;
`ifdef PS2_PARITY_CHECK_EN
  assign accept = data_in & (^sh_q ^ par_q);
`else
  logic par_unused;
  assign par_unused = par_q;
  assign accept = data_in;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    dout_d  = dout_q;
    bsy_d   = bsy_q;
    case (state_q)
      IDLE: if (!data_in) begin
        state_d = DATA;
        cnt_d   = 3'd0;
        bsy_d   = 1'b1;
      end
      DATA: begin
        sh_d[cnt_q] = data_in;
        cnt_d       = cnt_q + 3'd1;
        state_d     = (cnt_q == 3'd7) ? PARITY : DATA;
      end
      PARITY: begin
        par_d   = data_in;
        state_d = STOP;
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          dout_d = sh_q;
          bsy_d  = 1'b0;
        end
      end
    endcase
  end
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      sh_q    <= 8'h00;
      par_q   <= 1'b0;
      dout_q  <= 8'h00;
      bsy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      bsy_q   <= bsy_d;
    end
  end
  assign data_out = dout_q;
  assign bsy      = bsy_q;
endmodule

// File: tb/tb_ps2_rx_frame_decoder.sv
// tb_ps2_rx_frame_decoder: randomized frame-level bench with a behavioural model for ps2_rx_frame_decoder.
`timescale 1ns/1ps
module tb_ps2_rx_frame_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data_in = 1'b1;
  logic [7:0] data_out;
  logic       bsy;
  logic [7:0] exp_dout = 8'h00;
  logic       exp_bsy = 1'b1;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         run_cmp = 1'b0;

  always #33333 clk = ~clk;

  ps2_rx_frame_decoder dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out), .bsy(bsy)
  );

  function automatic bit parity_ok(logic [7:0] d, logic p);
`ifdef PS2_PARITY_CHECK_EN
    return ^{d, p};
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(string nm, logic [8:0] act, logic [8:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got bsy=%b data_out=%h, want bsy=%b data_out=%h at %0t",
               nm, act[8], act[7:0], want[8], want[7:0], $time);
    end
  endtask

  // Outputs only move on falling edges, so the rising edge is a stable sampling point.
  always @(posedge clk) if (run_cmp) chk("cycle", {bsy, data_out}, {exp_bsy, exp_dout});

  task automatic send_bit(logic b);
    @(posedge clk);
    #1 data_in = b;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic start_frame();
    send_bit(1'b0);
    exp_bsy = 1'b1;
  endtask

  task automatic finish_frame(logic [7:0] d, logic p, logic s);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    if (s && parity_ok(d, p)) begin
      exp_dout = d;
      exp_bsy  = 1'b0;
    end
  endtask

  task automatic send_frame(logic [7:0] d, logic p, logic s);
    start_frame();
    finish_frame(d, p, s);
  endtask

  initial begin
    #10 rst = 1'b1;
    run_cmp = 1'b1;
    repeat (2) @(posedge clk);
    chk("reset", {bsy, data_out}, 9'h100);
    @(posedge clk);
    #100 rst = 1'b0;
    idle(2);
    send_frame(8'h15, 1'b0, 1'b1);
    chk("q_frame", {bsy, data_out}, {1'b0, 8'h15});
    idle(2);
    start_frame();
    chk("h_mid", {bsy, data_out}, {1'b1, 8'h15});
    finish_frame(8'h33, 1'b1, 1'b1);
    chk("h_frame", {bsy, data_out}, {1'b0, 8'h33});
    for (int k = 0; k < 4; k++) begin
      start_frame();
      chk("held_start", {bsy, data_out}, {1'b1, k == 0 ? 8'h33 : 8'h15});
      finish_frame(8'h15, 1'b0, 1'b1);
      chk("held_stop", {bsy, data_out}, {1'b0, 8'h15});
    end
    send_frame(8'h2A, 1'b0, 1'b0);
    chk("stop_err", {bsy, data_out}, {1'b1, 8'h15});
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("after_err", {bsy, data_out}, {1'b0, 8'h1C});
    start_frame();
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    #1000 rst = 1'b1;
    exp_dout = 8'h00;
    exp_bsy  = 1'b1;
    #1 chk("mid_reset", {bsy, data_out}, 9'h100);
    data_in = 1'b1;
    idle(2);
    @(posedge clk);
    #100 rst = 1'b0;
    send_frame(8'h15, 1'b0, 1'b1);
    chk("post_reset", {bsy, data_out}, {1'b0, 8'h15});
    send_frame(8'h15, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    chk("bad_parity", {bsy, data_out}, {1'b1, 8'h15});
`else
    chk("bad_parity", {bsy, data_out}, {1'b0, 8'h15});
`endif
    for (int k = 0; k < 200; k++) begin
      logic [7:0] d;
      logic       p, s;
      d = 8'($urandom);
      p = ~^d ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 7) != 0);
      send_frame(d, p, s);
      idle($urandom_range(0, 2));
    end
    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
